dmem_arbiter: RTL

- Shares single-ported DMEM (port A of the dual-port RAM) between the CPU load/store path and the CCD capture DMA engine.
- Grants one access per cycle. CPU has fixed priority; the DMA may lock the port for a burst.
- Steers registered read data back to the requester that issued the read.
- Sits between cpu/ccd DMA and ram in the top level, replacing the direct CPU-to-DMEM wiring.

---
 rtl/dmem_arb_pkg.sv | 21 ++
 rtl/dmem_rd_tag_pipe.sv | 31 +++
 rtl/dmem_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the DMEM port-A arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_arb_pkg;

    localparam int AW_DEF = 11;
    localparam int DW_DEF = 16;

    // ARB: fixed-priority arbitration; DMA_BURST: port locked to the DMA
    typedef enum logic {
        ARB       = 1'b0,
        DMA_BURST = 1'b1
    } arb_state_t;

    // One entry per issued read: who gets the data when mem_q comes back
    typedef struct packed {
        logic valid;
        logic is_dma;
    } rd_tag_t;

endpackage

// File: rtl/dmem_rd_tag_pipe.sv
// Owner-tag delay line that tracks in-flight DMEM reads.
// Latency: tag_out equals tag_in delayed by exactly RD_LAT cycles.
// Backpressure: none; shifts every cycle, reset discards all in-flight tags.
module dmem_rd_tag_pipe
    import dmem_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t [RD_LAT-1:0] stages;

    // Shift tags one stage per cycle; reset drops every pending read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stages <= '0;
        end else begin
            stages[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign tag_out = stages[RD_LAT-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Shares DMEM port A between CPU (fixed priority) and CCD DMA (burst lock); DMEM_ARB_FAIR_EN adds DMA anti-starvation.
// Latency: grant and mem_* issue in the request cycle; read data returns RD_LAT cycles after the grant.
// Backpressure: a requester holds req until its gnt; one gnt per cycle, CPU stalls during a DMA burst.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_wr,
    input  logic [15:0]   cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_wr,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    input  logic          dma_last,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_ren,
    output logic          mem_wren,
    input  logic [DW-1:0] mem_q
);

    arb_state_t    state;
    logic          fair_win;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_wdata;
    rd_tag_t       tag_in;
    rd_tag_t       tag_out;

    // Upper CPU address bits alias into DMEM and are deliberately dropped
    logic unused_cpu_addr_hi;
    assign unused_cpu_addr_hi = ^cpu_addr[15:AW];

`ifdef DMEM_ARB_FAIR_EN
    localparam int WCW = $clog2(MAX_WAIT + 1);
    logic [WCW-1:0] wait_cnt;

    // Count cycles the DMA has been kept waiting, saturating at MAX_WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (dma_gnt) begin
            wait_cnt <= '0;
        end else if (dma_req && (wait_cnt != WCW'(MAX_WAIT))) begin
            wait_cnt <= wait_cnt + WCW'(1);
        end
    end

    assign fair_win = (wait_cnt == WCW'(MAX_WAIT)) && dma_req;
`else
    assign fair_win = 1'b0;
`endif

    // Grant selection: burst lock first, then CPU priority unless the DMA has starved
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (!rst) begin
            if (state == DMA_BURST) begin
                dma_gnt = dma_req;
            end else if (cpu_req && !fair_win) begin
                cpu_gnt = 1'b1;
            end else begin
                dma_gnt = dma_req;
            end
        end
    end

    // Burst lock: enter on a non-final DMA beat, leave on the last beat or an idle cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB;
        end else begin
            case (state)
                ARB:       if (dma_gnt && !dma_last) state <= DMA_BURST;
                DMA_BURST: if (!dma_req || dma_last) state <= ARB;
                default:   state <= ARB;
            endcase
        end
    end

    // Remember the last issued address/data so idle cycles do not toggle the RAM bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_addr  <= '0;
            last_wdata <= '0;
        end else if (cpu_gnt || dma_gnt) begin
            last_addr  <= mem_addr;
            last_wdata <= mem_wdata;
        end
    end

    assign mem_addr  = cpu_gnt ? cpu_addr[AW-1:0] : (dma_gnt ? dma_addr  : last_addr);
    assign mem_wdata = cpu_gnt ? cpu_wdata        : (dma_gnt ? dma_wdata : last_wdata);
    assign mem_ren   = (cpu_gnt && !cpu_wr) || (dma_gnt && !dma_wr);
    assign mem_wren  = (cpu_gnt && cpu_wr)  || (dma_gnt && dma_wr);

    assign tag_in.valid  = mem_ren;
    assign tag_in.is_dma = dma_gnt;

    dmem_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign cpu_rvalid = tag_out.valid && !tag_out.is_dma;
    assign dma_rvalid = tag_out.valid && tag_out.is_dma;
    assign cpu_rdata  = mem_q;
    assign dma_rdata  = mem_q;

endmodule
